// File: rtl/palette_lookup_arbiter.sv
// Round-robin arbiter sharing one combinational palette ROM among NREQ requesters.
// A single response register holds the looked-up colour until the consumer takes it.
module palette_lookup_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IW   = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_index,
    output logic [NREQ-1:0]   req_ready,
    output logic [7:0]        pal_index,
    input  logic [3:0]        pal_red,
    input  logic [3:0]        pal_green,
    input  logic [3:0]        pal_blue,
    output logic              rsp_valid,
    output logic [IW-1:0]     rsp_id,
    output logic [11:0]       rsp_rgb,
    output logic              rsp_transparent,
    input  logic              rsp_ready,
    output logic [15:0]       lookup_count
);

    localparam int unsigned CW = 16;

    logic [IW-1:0] last_grant;
    logic [IW-1:0] winner;
    logic [IW-1:0] cand;
    logic [7:0]    win_index;
    logic          found;
    logic          any_valid;
    logic          accept;

    // Round-robin search starting just after the last grant, wrapping at NREQ.
    always_comb begin
        winner = last_grant;
        cand   = last_grant;
        found  = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = (cand == IW'(NREQ - 1)) ? '0 : cand + IW'(1);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Route the winner's index to the ROM; zero when nobody asks.
    always_comb begin
        win_index = 8'h00;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (IW'(i) == winner) begin
                win_index = req_index[8*i +: 8];
            end
        end
        any_valid = |req_valid;
        pal_index = any_valid ? win_index : 8'h00;
    end

    // Accept when the response slot is free or draining this cycle; never during reset.
    always_comb begin
        accept    = any_valid && (!rsp_valid || rsp_ready) && !reset;
        req_ready = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            req_ready[i] = accept && (IW'(i) == winner);
        end
    end

    // Response register, grant pointer and saturating lookup counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid       <= 1'b0;
            rsp_id          <= '0;
            rsp_rgb         <= 12'h000;
            rsp_transparent <= 1'b0;
            lookup_count    <= '0;
            last_grant      <= IW'(NREQ - 1);
        end else if (accept) begin
            rsp_valid       <= 1'b1;
            rsp_id          <= winner;
            rsp_rgb         <= {pal_red, pal_green, pal_blue};
            rsp_transparent <= (pal_index == 8'h00);
            last_grant      <= winner;
            if (lookup_count != {CW{1'b1}}) begin
                lookup_count <= lookup_count + CW'(1);
            end
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule
